button_event: RTL and testbench

Classifies the debounced, synchronised push-button level into single-cycle events: press, release, short press, long press and auto-repeat. It also keeps a wrapping mode selector that advances on each short press. It sits directly downstream of the button debouncer, takes its clean level, and drives the video pipeline's mode and pattern select logic.

---
 rtl/button_event.sv | 138 +++++++++++++
 tb/tb_button_event.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// button_event: turns the debounced button level into press, release,
// short, long and auto-repeat pulses, plus a wrapping mode selector.
//
// Parameters
//   LONG_CYCLES    hold time in clk cycles before a press counts as long (>= 2)
//   REPEAT_CYCLES  auto-repeat period in clk cycles during a long hold (>= 2)
//   NUM_MODES      number of selector values (>= 2)
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   btn_in         debounced, synchronised button level (1 = pressed)
//   press_pulse    one cycle on the press edge
//   release_pulse  one cycle on every release edge
//   short_pulse    one cycle on release of a hold shorter than LONG_CYCLES
//   long_pulse     one cycle when the hold reaches LONG_CYCLES
//   repeat_pulse   one cycle every REPEAT_CYCLES after long_pulse while held
//   held           high from the press edge until the release edge
//   sel            mode selector, advanced by each short press, wraps
module button_event #(
   parameter int LONG_CYCLES   = 62_500_000,
   parameter int REPEAT_CYCLES = 12_500_000,
   parameter int NUM_MODES     = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         btn_in,
   output logic                         press_pulse,
   output logic                         release_pulse,
   output logic                         short_pulse,
   output logic                         long_pulse,
   output logic                         repeat_pulse,
   output logic                         held,
   output logic [$clog2(NUM_MODES)-1:0] sel
);

   localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ?
                         LONG_CYCLES : REPEAT_CYCLES;
   localparam int CW = $clog2(MAXC);
   localparam int SW = $clog2(NUM_MODES);

   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic [SW-1:0] SEL_LAST  = SW'(NUM_MODES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG_HELD
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] count, count_nx;
   logic          press_nx, release_nx, short_nx;
   logic          long_nx, repeat_nx, held_nx;
   logic [SW-1:0] sel_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
         sel           <= '0;
      end else begin
         state         <= state_nx;
         count         <= count_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         short_pulse   <= short_nx;
         long_pulse    <= long_nx;
         repeat_pulse  <= repeat_nx;
         held          <= held_nx;
         sel           <= sel_nx;
      end
   end

   // Release is tested first so it wins over a threshold hit.
   always_comb begin
      state_nx   = state;
      count_nx   = count;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      short_nx   = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
      held_nx    = held;
      sel_nx     = sel;
      unique case (state)
         IDLE: begin
            if (btn_in) begin
               state_nx = PRESSED;
               count_nx = '0;
               press_nx = 1'b1;
               held_nx  = 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_in) begin
               state_nx   = IDLE;
               count_nx   = '0;
               release_nx = 1'b1;
               short_nx   = 1'b1;
               held_nx    = 1'b0;
               sel_nx     = (sel == SEL_LAST) ? '0 : sel + SW'(1);
            end else if (count == LONG_LAST) begin
               state_nx = LONG_HELD;
               count_nx = '0;
               long_nx  = 1'b1;
            end else begin
               count_nx = count + CW'(1);
            end
         end
         LONG_HELD: begin
            if (!btn_in) begin
               state_nx   = IDLE;
               count_nx   = '0;
               release_nx = 1'b1;
               held_nx    = 1'b0;
            end else if (count == REP_LAST) begin
               count_nx  = '0;
               repeat_nx = 1'b1;
            end else begin
               count_nx = count + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            count_nx = '0;
            held_nx  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed and randomised checks of button_event
// with LONG_CYCLES=10, REPEAT_CYCLES=4, NUM_MODES=3.
module tb_button_event;

   localparam int L  = 10;
   localparam int R  = 4;
   localparam int NM = 3;

   // ev = {press, release, short, long, repeat, held}
   localparam logic [5:0] EV_N  = 6'b000000;
   localparam logic [5:0] EV_P  = 6'b100001;
   localparam logic [5:0] EV_H  = 6'b000001;
   localparam logic [5:0] EV_RS = 6'b011000;
   localparam logic [5:0] EV_R  = 6'b010000;
   localparam logic [5:0] EV_L  = 6'b000101;
   localparam logic [5:0] EV_RP = 6'b000011;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_in = 1'b0;
   logic       press_pulse, release_pulse, short_pulse;
   logic       long_pulse, repeat_pulse, held;
   logic [1:0] sel;

   int vectors = 0;
   int miscompares = 0;
   int pc = 0;
   int rc = 0;

   logic [5:0] ev;
   assign ev = {press_pulse, release_pulse, short_pulse,
                long_pulse, repeat_pulse, held};

   button_event #(
      .LONG_CYCLES  (L),
      .REPEAT_CYCLES(R),
      .NUM_MODES    (NM)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_in       (btn_in),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .sel          (sel)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // Expected events for the t-th consecutive high sample of a hold.
   function automatic logic [5:0] exp_hi(input int t);
      if (t == 1) return EV_P;
      if (t == L + 1) return EV_L;
      if (t > L + 1 && ((t - 1 - L) % R) == 0) return EV_RP;
      return EV_H;
   endfunction

   function automatic logic [1:0] inc(input logic [1:0] s);
      return (s == 2'(NM - 1)) ? 2'd0 : s + 2'd1;
   endfunction

   task automatic step(input logic b, input logic [5:0] e,
                       input logic [1:0] s, input string tag);
      btn_in = b;
      @(posedge clk);
      #1;
      check({tag, ".ev"}, 32'(ev), 32'(e));
      check({tag, ".sel"}, 32'(sel), 32'(s));
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      btn_in = 1'b0;
      #1;
      check("rst.ev", 32'(ev), 32'(EV_N));
      check("rst.sel", 32'(sel), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic props();
      pc += int'(press_pulse);
      rc += int'(release_pulse);
      check("excl", 32'($onehot0({press_pulse, release_pulse,
                                  long_pulse, repeat_pulse})), 32'd1);
      check("short_rel", 32'(!short_pulse || release_pulse), 32'd1);
      check("sel_rng", 32'(sel < 2'(NM)), 32'd1);
      check("bal", 32'((pc - rc) >= 0 && (pc - rc) <= 1), 32'd1);
   endtask

   initial begin
      logic [1:0] es;
      int         t;
      int         hi;
      int         lo;

      // basic short press of 3 samples
      do_reset();
      step(1'b1, EV_P,  2'd0, "t1.e1");
      step(1'b1, EV_H,  2'd0, "t1.e2");
      step(1'b1, EV_H,  2'd0, "t1.e3");
      step(1'b0, EV_RS, 2'd1, "t1.e4");
      step(1'b0, EV_N,  2'd1, "t1.e5");

      // four short presses, sel 1,2,0,1
      do_reset();
      es = 2'd0;
      repeat (4) begin
         step(1'b1, EV_P, es, "t2.p");
         step(1'b1, EV_H, es, "t2.h");
         es = inc(es);
         step(1'b0, EV_RS, es, "t2.r");
         step(1'b0, EV_N, es, "t2.g");
      end
      check("t2.final", 32'(sel), 32'd1);

      // 20-cycle hold: long at P+10, repeats at P+14, P+18
      for (int i = 0; i < 20; i++)
         step(1'b1, exp_hi(i + 1), es, "t3.hold");
      step(1'b0, EV_R, es, "t3.rel");
      step(1'b0, EV_N, es, "t3.idle");

      // release on the long threshold edge is a short press
      for (int i = 0; i < L; i++)
         step(1'b1, exp_hi(i + 1), es, "t4.hold");
      es = inc(es);
      step(1'b0, EV_RS, es, "t4.rel");
      step(1'b0, EV_N, es, "t4.idle");

      // reset during a long hold
      for (int i = 0; i < 12; i++)
         step(1'b1, exp_hi(i + 1), es, "t5.hold");
      reset = 1'b1;
      #1;
      check("t5.async.ev", 32'(ev), 32'(EV_N));
      check("t5.async.sel", 32'(sel), 32'd0);
      @(posedge clk);
      #1;
      check("t5.inrst.ev", 32'(ev), 32'(EV_N));
      #2;
      reset = 1'b0;
      es = 2'd0;
      step(1'b1, EV_P, es, "t5.repress");
      step(1'b1, EV_H, es, "t5.h");
      es = inc(es);
      step(1'b0, EV_RS, es, "t5.rel");
      step(1'b0, EV_N, es, "t5.idle");

      // random holds against a behavioural hold-length model
      do_reset();
      es = 2'd0;
      t  = 0;
      pc = 0;
      rc = 0;
      for (int seg = 0; seg < 25; seg++) begin
         hi = $urandom_range(22, 1);
         lo = $urandom_range(3, 1);
         for (int j = 0; j < hi; j++) begin
            t++;
            step(1'b1, exp_hi(t), es, "rnd.hi");
            props();
         end
         for (int j = 0; j < lo; j++) begin
            if (t == 0) begin
               step(1'b0, EV_N, es, "rnd.lo");
            end else if (t <= L) begin
               es = inc(es);
               step(1'b0, EV_RS, es, "rnd.short");
            end else begin
               step(1'b0, EV_R, es, "rnd.rel");
            end
            t = 0;
            props();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
